l2_model: RTL and testbench
===========================

L2_MODEL -- requirements
Module: l2_model

Interface
REQ-001 Parameter: BLOCK_SIZE, 2, words per L1 block; shared with bus controller.
REQ-002 Parameter: DEPTH, 256, number of 32-bit words stored.
REQ-003 Parameter: LATENCY, 4, BUSY cycles per access (legal range 1..255).
REQ-004 Parameter: BASE_ADDR, 32'h0, byte address of word 0.
REQ-005 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 Port: nRST  input  1  reset, asynchronous, active-low.
REQ-007 Port: l2REN  input  1  read-block request from the bus controller, held until serviced.
REQ-008 Port: l2WEN  input  1  write-word request from the bus controller, held until serviced.
REQ-009 Port: l2addr  input  32  byte address of the request.
REQ-010 Port: l2store  input  32  write data word.
REQ-011 Port: l2load  output  32*BLOCK_SIZE  read block; word i occupies bits [32i+31:32i].
REQ-012 Port: l2state  output  2 (l2_state_t)  L2_FREE / L2_BUSY / L2_ACCESS / L2_ERROR.

Function
REQ-013 The block SHALL implement a four-state FSM whose state is driven directly on l2state.
REQ-014 FREE: a request (l2REN xor l2WEN) with a legal address SHALL latch addr/op/data, load the counter with LATENCY-1, and enter BUSY next cycle.
REQ-015 An address is legal iff addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR+4*DEPTH; otherwise FREE SHALL go to ERROR.
REQ-016 l2REN and l2WEN both high in FREE SHALL go to ERROR.
REQ-017 BUSY: the counter SHALL decrement each cycle; at counter==0 the next state SHALL be ACCESS, so BUSY lasts exactly LATENCY cycles.
REQ-018 BUSY: if both l2REN and l2WEN are sampled low, the block SHALL abort to FREE with no memory update and l2load unchanged.
REQ-019 Changes to l2addr/l2store during BUSY SHALL be ignored; latched values are used.
REQ-020 Read: on the BUSY->ACCESS edge, l2load word i SHALL be loaded with mem[base+i], base = word index with its low log2(BLOCK_SIZE) bits cleared.
REQ-021 Write: on the BUSY->ACCESS edge, mem[word index] SHALL be written with the latched l2store; l2load unchanged.
REQ-022 ACCESS SHALL last exactly one cycle and unconditionally go to FREE, even if a request is still asserted.
REQ-023 ERROR SHALL last exactly one cycle, go to FREE, and leave memory and l2load unchanged.
REQ-024 l2load SHALL hold its value at all times except the BUSY->ACCESS edge of a read.
REQ-025 Back-to-back requests SHALL incur at least one FREE cycle between ACCESS and the next BUSY.
REQ-026 Read-after-write to the same word SHALL return the written data.

Reset
REQ-027 nRST low SHALL asynchronously force l2state=L2_FREE, counter=0, l2load=0, latched regs=0, and all memory words=0.
REQ-028 Reset asserted mid-BUSY SHALL discard the pending access; no write is committed.

Structure
REQ-029 l2_state_t, bus_word_t, transfer_width_t, and BLOCK_SIZE SHALL come from the shared bus package; no local redefinition.
REQ-030 Storage SHALL be a sub-module l2_storage: one 32-bit write port, one BLOCK_SIZE-word aligned read port, async reset-to-zero.
REQ-031 FSM, counter, and address check SHALL reside in l2_model.

Verification
REQ-032 Reset, then WEN addr 0x10 data 0xDEADBEEF: BUSY for 4 cycles -> ACCESS 1 cycle -> FREE; the following REN addr 0x10 gives l2load={0x00000000,0xDEADBEEF} (word1,word0) in ACCESS.
REQ-033 REN addr 0x2 (misaligned) and REN addr 0x400 (DEPTH=256): each gives ERROR 1 cycle then FREE; l2load unchanged.
REQ-034 REN and WEN high together at addr 0x8: ERROR 1 cycle; mem[2] unchanged on readback.
REQ-035 WEN addr 0x20 data 0x1234, WEN dropped in 2nd BUSY cycle: FREE next cycle; readback of 0x20 returns 0.
REQ-036 REN held high through ACCESS: one FREE cycle follows, then a new BUSY; l2load is reloaded with identical data.
REQ-037 nRST pulsed during BUSY of WEN 0x30 data 0xA5A5A5A5: state FREE immediately; readback of 0x30 returns 0.

Source files
------------

// File: rtl/l2_model_pkg.sv
// Shared bus definitions: L2 handshake states, bus word type, transfer widths
// and the L1 block size agreed between the bus controller and the L2 model.
package l2_model_pkg;

  localparam int BLOCK_SIZE = 2;

  typedef logic [31:0] bus_word_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  // A write moves a single word; a read moves a whole L1 block.
  typedef enum logic [1:0] {
    XFER_WORD  = 2'd0,
    XFER_BLOCK = 2'd1
  } transfer_width_t;

  // Clear the low log2(BLOCK_SIZE) bits of a word index to find its block base.
  function automatic logic [31:0] block_align(logic [31:0] index);
    return index & ~(32'(BLOCK_SIZE) - 32'd1);
  endfunction

endpackage

// File: rtl/l2_model_storage.sv
// Word-addressed backing store for the L2 model: one 32-bit write port and one
// aligned BLOCK_SIZE-word combinational read port, cleared by reset.
module l2_storage
  import l2_model_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_index,
  input  bus_word_t                  wr_data,
  input  logic [IDX_W-1:0]           rd_base,
  output logic [32*BLOCK_SIZE-1:0]   rd_data
);

  bus_word_t mem [DEPTH];

  // Memory words: all zero after reset, single-word update on a write commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Gather the aligned block; the base has its low bits clear so OR selects each word.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      rd_data[32*i +: 32] = mem[rd_base | IDX_W'(i)];
    end
  end

endmodule

// File: rtl/l2_model.sv
// L2 memory model behind the bus controller: FREE/BUSY/ACCESS/ERROR handshake,
// fixed access latency, address legality check, block reads and word writes.
module l2_model
  import l2_model_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      l2REN,
  input  logic                      l2WEN,
  input  bus_word_t                 l2addr,
  input  bus_word_t                 l2store,
  output logic [32*BLOCK_SIZE-1:0]  l2load,
  output l2_state_t                 l2state
);

  localparam int IDX_W = $clog2(DEPTH);

  l2_state_t                  state;
  l2_state_t                  next_state;
  logic [7:0]                 count;
  logic [IDX_W-1:0]           lat_index;
  bus_word_t                  lat_data;
  transfer_width_t            lat_op;
  logic                       start;
  logic                       commit;
  logic                       addr_ok;
  logic [IDX_W-1:0]           req_index;
  logic [IDX_W-1:0]           rd_base;
  logic [32*BLOCK_SIZE-1:0]   rd_data;
  logic                       wr_en;

  assign addr_ok = (l2addr[1:0] == 2'b00) &&
                   (l2addr >= BASE_ADDR) &&
                   ({1'b0, l2addr} < ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
  assign req_index = IDX_W'((l2addr - BASE_ADDR) >> 2);
  assign rd_base   = IDX_W'(block_align(32'(lat_index)));
  assign wr_en     = commit && (lat_op == XFER_WORD);
  assign l2state   = state;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= L2_FREE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start latches a request, commit marks the BUSY->ACCESS edge.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    commit     = 1'b0;
    case (state)
      L2_FREE: begin
        if (l2REN && l2WEN) begin
          next_state = L2_ERROR;
        end else if (l2REN || l2WEN) begin
          if (addr_ok) begin
            next_state = L2_BUSY;
            start      = 1'b1;
          end else begin
            next_state = L2_ERROR;
          end
        end
      end
      L2_BUSY: begin
        if (!l2REN && !l2WEN) begin
          next_state = L2_FREE;
        end else if (count == 8'd0) begin
          next_state = L2_ACCESS;
          commit     = 1'b1;
        end
      end
      L2_ACCESS: next_state = L2_FREE;
      L2_ERROR:  next_state = L2_FREE;
      default:   next_state = L2_FREE;
    endcase
  end

  // Latency counter and the request captured when leaving FREE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count     <= 8'd0;
      lat_index <= '0;
      lat_data  <= '0;
      lat_op    <= XFER_WORD;
    end else if (start) begin
      count     <= 8'(LATENCY - 1);
      lat_index <= req_index;
      lat_data  <= l2store;
      lat_op    <= l2REN ? XFER_BLOCK : XFER_WORD;
    end else if ((state == L2_BUSY) && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // Read data only changes on the commit edge of a block read.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      l2load <= '0;
    end else if (commit && (lat_op == XFER_BLOCK)) begin
      l2load <= rd_data;
    end
  end

  l2_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk      (CLK),
    .rst_n    (nRST),
    .wr_en    (wr_en),
    .wr_index (lat_index),
    .wr_data  (lat_data),
    .rd_base  (rd_base),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_l2_model.sv
// Self-checking bench for l2_model: directed scenarios plus randomized
// transactions compared every cycle against a transaction-level memory model.
module tb_l2_model;
  import l2_model_pkg::*;

  localparam int          DEPTH   = 256;
  localparam int          LATENCY = 4;
  localparam logic [31:0] BASE    = 32'h0;
  localparam int          LW      = 32 * BLOCK_SIZE;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            l2REN = 1'b0;
  logic            l2WEN = 1'b0;
  logic [31:0]     l2addr = '0;
  logic [31:0]     l2store = '0;
  logic [LW-1:0]   l2load;
  l2_state_t       l2state;

  int              total = 0;
  int              bad = 0;
  int              busy_seen = 0;
  l2_state_t       exp_state = L2_FREE;
  logic [LW-1:0]   exp_load = '0;
  logic [31:0]     mem_model [DEPTH];

  l2_model #(
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .l2REN   (l2REN),
    .l2WEN   (l2WEN),
    .l2addr  (l2addr),
    .l2store (l2store),
    .l2load  (l2load),
    .l2state (l2state)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic check_output(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, just after the rising edge, compare against the model.
  always @(posedge CLK) begin
    #1;
    check_output("state", LW'(l2state), LW'(exp_state));
    check_output("load", l2load, exp_load);
    if (l2state == L2_BUSY) busy_seen++;
  end

  function automatic bit addr_legal(logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a[1:0] == 2'b00) && (la >= longint'(BASE)) &&
           (la < longint'(BASE) + longint'(4 * DEPTH));
  endfunction

  function automatic logic [LW-1:0] model_block(int idx);
    logic [LW-1:0] r;
    int base;
    base = idx - (idx % BLOCK_SIZE);
    r = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) r[32*i +: 32] = mem_model[base + i];
    return r;
  endfunction

  // One transaction issued from a FREE cycle (called at a falling edge);
  // abort_at = k drops the request during BUSY cycle k, hold keeps it through ACCESS.
  task automatic apply_stimulus(bit ren, bit wen, logic [31:0] addr, logic [31:0] data,
                                int abort_at, bit hold);
    int idx;
    l2REN = ren; l2WEN = wen; l2addr = addr; l2store = data;
    if (!(ren ^ wen) || !addr_legal(addr)) begin
      exp_state = L2_ERROR;
      @(negedge CLK);
      l2REN = 1'b0; l2WEN = 1'b0;
      exp_state = L2_FREE;
      @(negedge CLK);
      return;
    end
    idx = int'((addr - BASE) >> 2);
    exp_state = L2_BUSY;
    @(negedge CLK);
    for (int j = 1; j <= LATENCY; j++) begin
      l2addr = $urandom; l2store = $urandom;
      if (j == abort_at) begin
        l2REN = 1'b0; l2WEN = 1'b0;
        exp_state = L2_FREE;
        @(negedge CLK);
        return;
      end
      if (j < LATENCY) begin
        exp_state = L2_BUSY;
      end else begin
        exp_state = L2_ACCESS;
        if (ren) exp_load = model_block(idx);
        else mem_model[idx] = data;
      end
      @(negedge CLK);
    end
    l2addr = addr; l2store = data;
    if (!hold) begin
      l2REN = 1'b0; l2WEN = 1'b0;
    end
    exp_state = L2_FREE;
    @(negedge CLK);
  endtask

  // Reset pulse in the middle of a write's BUSY phase.
  task automatic reset_during_busy();
    l2WEN = 1'b1; l2addr = 32'h30; l2store = 32'hA5A5A5A5;
    exp_state = L2_BUSY;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    exp_state = L2_FREE;
    exp_load = '0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    #1;
    check_output("reset_mid_busy_state", LW'(l2state), LW'(L2_FREE));
    check_output("reset_mid_busy_load", l2load, '0);
    l2WEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int kind;
    int widx;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check_output("reset_state", LW'(l2state), LW'(L2_FREE));
    check_output("reset_load", l2load, '0);

    busy_seen = 0;
    apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    check_output("write_busy_cycles", LW'(busy_seen), LW'(4));
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    check_output("read_0x10", l2load, 64'h00000000_DEADBEEF);

    apply_stimulus(1'b1, 1'b0, 32'h2, 32'h0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h400, 32'h0, 0, 1'b0);
    check_output("load_after_errors", l2load, 64'h00000000_DEADBEEF);

    apply_stimulus(1'b0, 1'b1, 32'h8, 32'h55AA55AA, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 32'h8, 32'h77777777, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h8, 32'h0, 0, 1'b0);
    check_output("read_0x8_after_both", l2load, 64'h00000000_55AA55AA);

    apply_stimulus(1'b0, 1'b1, 32'h20, 32'h1234, 2, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    check_output("read_0x20_after_abort", l2load, 64'h0);

    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    check_output("read_0x10_held", l2load, 64'h00000000_DEADBEEF);

    reset_during_busy();
    apply_stimulus(1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b0);
    check_output("read_0x30_after_reset", l2load, 64'h0);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    check_output("read_0x10_after_reset", l2load, 64'h0);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      widx = ($urandom_range(0, 3) == 0) ? (DEPTH - 1 - $urandom_range(0, 3))
                                         : $urandom_range(0, 15);
      a = BASE + 32'(widx) * 32'd4;
      case (kind)
        0, 1, 2, 3:
          apply_stimulus(1'b1, 1'b0, a, $urandom,
                         ($urandom_range(0, 7) == 0) ? $urandom_range(1, LATENCY) : 0, 1'b0);
        4, 5, 6:
          apply_stimulus(1'b0, 1'b1, a, $urandom, 0, 1'b0);
        7:
          apply_stimulus(1'b1, ($urandom_range(0, 1) == 1), a, $urandom, 0, 1'b0);
        8: begin
          if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(1, 3));
          else a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255)) * 32'd4;
          apply_stimulus($urandom_range(0, 1) == 1, 1'b1, a, $urandom, 0, 1'b0);
        end
        default:
          apply_stimulus(1'b0, 1'b1, a, $urandom, $urandom_range(1, LATENCY), 1'b0);
      endcase
    end

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
